// File: rtl/phv_stage_fifo.sv
// ----------------------------------------------------------------------------
// phv_stage_fifo
//
// Elastic buffer placed between two match-action stages (or between the last
// stage and the deparser). PHVs arrive one per cycle with no backpressure on
// the input side. The upstream stage is told through stg_ready to stop
// injecting new packets while SLACK entries are still free. Those entries
// absorb PHVs that are already travelling through the upstream pipeline.
// If the buffer still fills up, further PHVs are dropped and counted.
//
// Parameters
//   PHV_LEN : PHV width in bits
//   DEPTH   : number of entries (power of two, >= 4)
//   SLACK   : entries held back for in-flight PHVs (1 <= SLACK < DEPTH)
//
// Ports
//   axis_clk      in   1           clock
//   aresetn       in   1           asynchronous active-low reset
//   phv_in        in   PHV_LEN     PHV from the upstream stage
//   phv_in_valid  in   1           push request (no backpressure)
//   stg_ready     out  1           registered "may inject new PHVs" to upstream
//   phv_out       out  PHV_LEN     head entry (zero when empty)
//   phv_out_valid out  1           head entry present
//   phv_out_ready in   1           downstream accepts the head entry
//   fifo_level    out  log2(D)+1   current occupancy
//   drop_cnt      out  16          saturating count of overflow drops
// ----------------------------------------------------------------------------
module phv_stage_fifo #(
    parameter int PHV_LEN = 1124,
    parameter int DEPTH   = 8,
    parameter int SLACK   = 4
) (
    input  logic                     axis_clk,
    input  logic                     aresetn,
    input  logic [PHV_LEN-1:0]       phv_in,
    input  logic                     phv_in_valid,
    output logic                     stg_ready,
    output logic [PHV_LEN-1:0]       phv_out,
    output logic                     phv_out_valid,
    input  logic                     phv_out_ready,
    output logic [$clog2(DEPTH):0]   fifo_level,
    output logic [15:0]              drop_cnt
);

    localparam int PTR_W = $clog2(DEPTH);
    localparam int LVL_W = PTR_W + 1;

    localparam logic [LVL_W-1:0] LVL_FULL  = LVL_W'(DEPTH);
    localparam logic [LVL_W-1:0] LVL_LIMIT = LVL_W'(DEPTH - SLACK);

    // Parameter sanity, caught at elaboration time.
    generate
        if ((DEPTH < 4) || ((DEPTH & (DEPTH - 1)) != 0)) begin : g_bad_depth
            $error("phv_stage_fifo: DEPTH must be a power of two and at least 4");
        end
        if ((SLACK < 1) || (SLACK >= DEPTH)) begin : g_bad_slack
            $error("phv_stage_fifo: SLACK must satisfy 1 <= SLACK < DEPTH");
        end
    endgenerate

    // Saturating 16-bit increment for the drop counter.
    function automatic logic [15:0] sat_inc16(input logic [15:0] v);
        return (v == 16'hFFFF) ? v : v + 16'd1;
    endfunction

    // ------------------------------------------------------------------------
    // State
    // ------------------------------------------------------------------------
    logic [PHV_LEN-1:0] mem [DEPTH];
    logic [PTR_W-1:0]   wr_ptr;
    logic [PTR_W-1:0]   rd_ptr;
    logic [LVL_W-1:0]   level_q;
    logic [15:0]        drop_q;
    logic               stg_ready_q;

    logic               is_full;
    logic               is_empty;
    logic               do_pop;
    logic               do_push;
    logic               do_drop;
    logic [LVL_W-1:0]   level_nxt;

    // ------------------------------------------------------------------------
    // Push / pop decision
    // ------------------------------------------------------------------------
    always_comb begin
        is_full   = (level_q == LVL_FULL);
        is_empty  = (level_q == '0);
        // phv_out_ready is meaningless while empty.
        do_pop    = !is_empty && phv_out_ready;
        // A full FIFO still takes a PHV when the head leaves on the same edge.
        do_push   = phv_in_valid && (!is_full || do_pop);
        do_drop   = phv_in_valid && is_full && !do_pop;

        level_nxt = level_q;
        case ({do_push, do_pop})
            2'b10:   level_nxt = level_q + LVL_W'(1);
            2'b01:   level_nxt = level_q - LVL_W'(1);
            default: level_nxt = level_q;
        endcase
    end

    // ------------------------------------------------------------------------
    // Storage: not reset. Only entries between the pointers are ever shown on
    // phv_out, and phv_out is forced to zero while empty.
    // ------------------------------------------------------------------------
    always_ff @(posedge axis_clk) begin
        if (do_push) begin
            mem[wr_ptr] <= phv_in;
        end
    end

    // ------------------------------------------------------------------------
    // Control registers
    // ------------------------------------------------------------------------
    always_ff @(posedge axis_clk or negedge aresetn) begin
        if (!aresetn) begin
            wr_ptr      <= '0;
            rd_ptr      <= '0;
            level_q     <= '0;
            drop_q      <= '0;
            stg_ready_q <= 1'b0;
        end else begin
            // Pointers are exactly log2(DEPTH) bits wide, so they wrap on their own.
            if (do_push) begin
                wr_ptr <= wr_ptr + PTR_W'(1);
            end
            if (do_pop) begin
                rd_ptr <= rd_ptr + PTR_W'(1);
            end
            if (do_drop) begin
                drop_q <= sat_inc16(drop_q);
            end
            level_q     <= level_nxt;
            // Looks at the level after this edge, so stg_ready drops on the
            // same edge that reaches the threshold.
            stg_ready_q <= (level_nxt < LVL_LIMIT);
        end
    end

    // ------------------------------------------------------------------------
    // Outputs
    // ------------------------------------------------------------------------
    always_comb begin
        phv_out_valid = !is_empty;
        phv_out       = is_empty ? '0 : mem[rd_ptr];
        fifo_level    = level_q;
        drop_cnt      = drop_q;
        stg_ready     = stg_ready_q;
    end

endmodule

// File: tb/tb_phv_stage_fifo.sv
module tb_phv_stage_fifo;

    localparam int PHV_LEN = 1124;
    localparam int DEPTH   = 8;
    localparam int SLACK   = 4;
    localparam int LVL_W   = $clog2(DEPTH) + 1;

    logic                 axis_clk;
    logic                 aresetn;
    logic [PHV_LEN-1:0]   phv_in;
    logic                 phv_in_valid;
    logic                 stg_ready;
    logic [PHV_LEN-1:0]   phv_out;
    logic                 phv_out_valid;
    logic                 phv_out_ready;
    logic [LVL_W-1:0]     fifo_level;
    logic [15:0]          drop_cnt;

    phv_stage_fifo #(
        .PHV_LEN(PHV_LEN),
        .DEPTH  (DEPTH),
        .SLACK  (SLACK)
    ) dut (
        .axis_clk     (axis_clk),
        .aresetn      (aresetn),
        .phv_in       (phv_in),
        .phv_in_valid (phv_in_valid),
        .stg_ready    (stg_ready),
        .phv_out      (phv_out),
        .phv_out_valid(phv_out_valid),
        .phv_out_ready(phv_out_ready),
        .fifo_level   (fifo_level),
        .drop_cnt     (drop_cnt)
    );

    initial axis_clk = 1'b0;
    always #5 axis_clk = ~axis_clk;

    int n_cmp = 0;
    int n_err = 0;

    // Reference model: an ordered queue of stored PHVs, a saturating drop
    // count and the registered ready flag.
    logic [PHV_LEN-1:0] q[$];
    int                 m_drop;
    logic               m_stg;

    task automatic chk(input string tag, input logic [PHV_LEN-1:0] obs,
                       input logic [PHV_LEN-1:0] exp);
        n_cmp++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: got(lo64)=%h want(lo64)=%h at %0t",
                     tag, obs[63:0], exp[63:0], $time);
        end
    endtask

    function automatic logic [PHV_LEN-1:0] rand_phv();
        logic [PHV_LEN-1:0] r;
        r = '0;
        for (int i = 0; i < (PHV_LEN + 31) / 32; i++) begin
            r = {r[PHV_LEN-33:0], 32'($urandom)};
        end
        return r;
    endfunction

    task automatic check_outputs(input string tag);
        logic [PHV_LEN-1:0] head;
        head = (q.size() != 0) ? q[0] : '0;
        chk({tag, ".valid"}, PHV_LEN'(phv_out_valid), PHV_LEN'(q.size() != 0));
        chk({tag, ".phv_out"}, phv_out, head);
        chk({tag, ".level"}, PHV_LEN'(fifo_level), PHV_LEN'(q.size()));
        chk({tag, ".drop"}, PHV_LEN'(drop_cnt), PHV_LEN'(m_drop));
        chk({tag, ".stg_ready"}, PHV_LEN'(stg_ready), PHV_LEN'(m_stg));
    endtask

    // One clock cycle: drive, check before the edge, update model at the edge.
    // Called and returns at posedge+1.
    task automatic step(input logic v, input logic [PHV_LEN-1:0] d, input logic r);
        logic pop;
        logic full;
        phv_in_valid  = v;
        phv_in        = d;
        phv_out_ready = r;
        @(negedge axis_clk);
        check_outputs("cyc");
        @(posedge axis_clk);
        full = (q.size() == DEPTH);
        pop  = (q.size() != 0) && r;
        if (pop) void'(q.pop_front());
        if (v) begin
            if (!full || pop) q.push_back(d);
            else if (m_drop < 65535) m_drop++;
        end
        m_stg = (q.size() < DEPTH - SLACK);
        #1;
    endtask

    // Asynchronous reset applied between edges; returns at posedge+1 with
    // reset released.
    task automatic do_reset(input string tag);
        phv_in_valid  = 1'b0;
        phv_out_ready = 1'b0;
        aresetn       = 1'b0;
        q.delete();
        m_drop = 0;
        m_stg  = 1'b0;
        #1;
        check_outputs({tag, ".async"});
        @(posedge axis_clk);
        #1;
        check_outputs({tag, ".held"});
        aresetn = 1'b1;
    endtask

    logic [PHV_LEN-1:0] a5;
    logic [PHV_LEN-1:0] pushed[10];

    initial begin
        aresetn       = 1'b0;
        phv_in        = '0;
        phv_in_valid  = 1'b0;
        phv_out_ready = 1'b0;
        m_drop        = 0;
        m_stg         = 1'b0;
        for (int i = 0; i < PHV_LEN; i++) a5[i] = (i % 8 == 0) || (i % 8 == 2) ||
                                                  (i % 8 == 5) || (i % 8 == 7);
        repeat (2) @(posedge axis_clk);
        #1;
        check_outputs("reset");
        aresetn = 1'b1;

        // stg_ready rises on the first edge after release.
        step(1'b0, '0, 1'b0);
        chk("stg_rise", PHV_LEN'(stg_ready), PHV_LEN'(1));

        // Single PHV through an empty FIFO with downstream ready.
        step(1'b1, a5, 1'b1);
        chk("single.valid", PHV_LEN'(phv_out_valid), PHV_LEN'(1));
        chk("single.data", phv_out, a5);
        chk("single.level1", PHV_LEN'(fifo_level), PHV_LEN'(1));
        step(1'b0, '0, 1'b1);
        chk("single.gone", PHV_LEN'(phv_out_valid), PHV_LEN'(0));
        chk("single.level0", PHV_LEN'(fifo_level), PHV_LEN'(0));

        // Four pushes with downstream stalled: stg_ready falls on the 4th edge.
        for (int i = 0; i < 4; i++) begin
            step(1'b1, rand_phv(), 1'b0);
            chk("thresh.stg", PHV_LEN'(stg_ready), PHV_LEN'(i < 3));
        end
        chk("thresh.level", PHV_LEN'(fifo_level), PHV_LEN'(4));
        // Holding while stalled keeps the head stable.
        step(1'b0, '0, 1'b0);
        step(1'b0, '0, 1'b0);
        // Push while stg_ready=0 still accepted.
        step(1'b1, rand_phv(), 1'b0);
        chk("advisory.level", PHV_LEN'(fifo_level), PHV_LEN'(5));
        repeat (6) step(1'b0, '0, 1'b1);

        // Overflow: 10 pushes into 8 entries, then drain in order.
        do_reset("rst1");
        for (int i = 0; i < 10; i++) begin
            pushed[i] = rand_phv();
            step(1'b1, pushed[i], 1'b0);
        end
        chk("ovf.level", PHV_LEN'(fifo_level), PHV_LEN'(8));
        chk("ovf.drop", PHV_LEN'(drop_cnt), PHV_LEN'(2));
        for (int i = 0; i < 8; i++) begin
            chk("ovf.order", phv_out, pushed[i]);
            step(1'b0, '0, 1'b1);
        end
        chk("ovf.empty", PHV_LEN'(phv_out_valid), PHV_LEN'(0));

        // Full FIFO, simultaneous push and pop across pointer wrap.
        do_reset("rst2");
        repeat (8) step(1'b1, rand_phv(), 1'b0);
        repeat (20) step(1'b1, rand_phv(), 1'b1);
        chk("wrap.level", PHV_LEN'(fifo_level), PHV_LEN'(8));
        chk("wrap.drop", PHV_LEN'(drop_cnt), PHV_LEN'(0));
        repeat (9) step(1'b0, '0, 1'b1);

        // Random traffic with varying push/pop bias.
        for (int ph = 0; ph < 4; ph++) begin
            int pv;
            int pr;
            pv = 30 + ph * 20;
            pr = 80 - ph * 20;
            for (int i = 0; i < 700; i++) begin
                step(($urandom_range(0, 99) < pv), rand_phv(),
                     ($urandom_range(0, 99) < pr));
            end
        end

        // Asynchronous reset with five stored PHVs.
        do_reset("rst3");
        repeat (5) step(1'b1, rand_phv(), 1'b0);
        chk("mid.level", PHV_LEN'(fifo_level), PHV_LEN'(5));
        do_reset("rst_mid");
        chk("mid.valid", PHV_LEN'(phv_out_valid), PHV_LEN'(0));
        step(1'b0, '0, 1'b1);
        chk("mid.stg", PHV_LEN'(stg_ready), PHV_LEN'(1));
        chk("mid.empty", PHV_LEN'(phv_out_valid), PHV_LEN'(0));

        // Drop counter saturation.
        repeat (8) step(1'b1, rand_phv(), 1'b0);
        for (int i = 0; i < 65540; i++) step(1'b1, phv_in ^ PHV_LEN'(i), 1'b0);
        chk("sat.drop", PHV_LEN'(drop_cnt), PHV_LEN'(16'hFFFF));
        repeat (5) step(1'b1, rand_phv(), 1'b0);
        chk("sat.hold", PHV_LEN'(drop_cnt), PHV_LEN'(16'hFFFF));
        chk("sat.level", PHV_LEN'(fifo_level), PHV_LEN'(8));
        repeat (9) step(1'b0, '0, 1'b1);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule

// File: doc/phv_stage_fifo.md
PHV_STAGE_FIFO -- requirements
Module: phv_stage_fifo

Interface
REQ-001 Parameter PHV_LEN, default 1124: PHV width in bits (48*8+32*8+16*8+5*20+256).
REQ-002 Parameter DEPTH, default 8: FIFO entries; a power of two, at least 4.
REQ-003 Parameter SLACK, default 4: entries reserved for PHVs already in flight in the upstream stage; 1 <= SLACK < DEPTH.
REQ-004 The block SHALL use one clock, axis_clk; reset aresetn is asynchronous and active-low.
REQ-005 Ports, one per line (name, direction, width, meaning):
- axis_clk, in, 1: clock.
- aresetn, in, 1: asynchronous active-low reset.
- phv_in, in, PHV_LEN: PHV from the upstream stage's phv_out.
- phv_in_valid, in, 1: push request; one PHV per cycle, no backpressure on this port.
- stg_ready, out, 1: registered permission for upstream to inject new PHVs.
- phv_out, out, PHV_LEN: head-of-FIFO PHV to the downstream stage or deparser.
- phv_out_valid, out, 1: head entry present.
- phv_out_ready, in, 1: downstream accepts the head entry.
- fifo_level, out, log2(DEPTH)+1: current occupancy.
- drop_cnt, out, 16: count of PHVs dropped on overflow.

Function
REQ-006 Storage SHALL be a circular buffer with a write pointer and a read pointer of log2(DEPTH) bits each, wrapping modulo DEPTH, plus an occupancy counter.
REQ-007 Push: when phv_in_valid=1 and the FIFO is not full, phv_in SHALL be written at the write pointer and the write pointer SHALL advance on that edge.
REQ-008 Pop: when phv_out_valid=1 and phv_out_ready=1, the read pointer SHALL advance on that edge.
REQ-009 phv_out_valid SHALL be 1 exactly when fifo_level != 0; phv_out SHALL equal the entry at the read pointer when valid and all-zero when not valid.
REQ-010 Latency: a PHV pushed into an empty FIFO at edge N SHALL appear with phv_out_valid=1 in the cycle after edge N; there is no combinational path from phv_in to phv_out.
REQ-011 fifo_level SHALL update each edge as +1 on push only, -1 on pop only, and unchanged on simultaneous push and pop or on neither.
REQ-012 Full with a simultaneous pop: the push SHALL be accepted, fifo_level stays DEPTH, and no drop occurs.
REQ-013 Full without a pop: the incoming PHV SHALL be discarded, FIFO contents and pointers stay unchanged, and drop_cnt increments by 1.
REQ-014 drop_cnt SHALL saturate at 16'hFFFF and never wrap.
REQ-015 Empty FIFO: phv_out_ready SHALL be ignored, with no pointer or level change.
REQ-016 stg_ready SHALL be a register loaded each edge with (next fifo_level < DEPTH - SLACK).
REQ-017 A PHV pushed while stg_ready=0 SHALL still be accepted if space exists; stg_ready is advisory.
REQ-018 FIFO order SHALL be strict: PHVs leave in arrival order, and no PHV is duplicated or reordered across pointer wrap.
REQ-019 phv_out SHALL hold stable while phv_out_valid=1 and phv_out_ready=0.

Reset
REQ-020 While aresetn=0, outputs SHALL be: phv_out_valid=0, phv_out=0, fifo_level=0, drop_cnt=0, stg_ready=0; pointers SHALL be 0.
REQ-021 Storage array contents SHALL NOT be reset.
REQ-022 stg_ready SHALL rise on the first axis_clk edge after aresetn deasserts.
REQ-023 Reset asserted mid-operation SHALL discard all stored PHVs immediately (asynchronously), with no partial pop visible afterwards.

Verification
REQ-024 Single push of PHV 0xA5... into an empty FIFO with phv_out_ready=1 -> phv_out_valid=1 for exactly one cycle, one cycle after the push; phv_out=0xA5...; fifo_level returns to 0.
REQ-025 Push 4 PHVs with phv_out_ready=0, DEPTH=8, SLACK=4 -> stg_ready falls on the 4th push edge; fifo_level=4.
REQ-026 Push 10 PHVs with phv_out_ready=0 -> fifo_level=8, drop_cnt=2; draining yields PHVs 1..8 in order.
REQ-027 FIFO full, then push and pop in the same cycle for 20 cycles -> fifo_level stays 8, drop_cnt=0, output order is preserved across pointer wrap.
REQ-028 Assert aresetn low while fifo_level=5 -> all outputs reach their reset values asynchronously; after release, stg_ready=1 after one edge and phv_out_valid=0.
REQ-029 Force 65,540 overflow drops -> drop_cnt=16'hFFFF and stays there.
